ghash_block_formatter: RTL

Produces the 128-bit block stream consumed by the GHASH core. Accepts AAD and ciphertext blocks (the final block of each section may be partial) and forwards them with zero padding. Tracks bit lengths and appends the GCM length block len(A)||len(C) as the final block, flagged with `m_last`. Sits between the AES-CTR datapath/AAD source and the GHASH core's `din_*` port.

---
 rtl/ghash_block_formatter_pkg.sv | 14 +
 rtl/ghash_block_formatter_byte_mask.sv | 20 ++
 rtl/ghash_block_formatter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ghash_block_formatter_pkg.sv
// Shared constants and FSM state encoding for the GHASH block formatter.
package ghash_block_formatter_pkg;

   localparam int GCM_BLOCK_BYTES = 16;
   localparam int GCM_LEN_W       = 64;
   localparam int GCM_BLOCK_W     = 8 * GCM_BLOCK_BYTES;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_LEN  = 2'd2
   } state_e;

endpackage

// File: rtl/ghash_block_formatter_byte_mask.sv
// Byte-count to keep-mask decode; byte 0 occupies the top byte lane.
module gcm_byte_mask
   import ghash_block_formatter_pkg::*;
(
   input  logic [4:0]             bytes_i,
   output logic [4:0]             bytes_clamped_o,
   output logic                   over_o,
   output logic [GCM_BLOCK_W-1:0] keep_o
);

   always_comb begin
      over_o          = (bytes_i > 5'(GCM_BLOCK_BYTES));
      bytes_clamped_o = over_o ? 5'(GCM_BLOCK_BYTES) : bytes_i;
      keep_o          = '0;
      for (int i = 0; i < GCM_BLOCK_BYTES; i++) begin
         if (5'(i) < bytes_clamped_o) keep_o[GCM_BLOCK_W-1-8*i -: 8] = 8'hFF;
      end
   end

endmodule

// File: rtl/ghash_block_formatter.sv
// Pads AAD/ciphertext blocks for GHASH and appends the len(A)||len(C) block.
//  state   | meaning
//  ST_IDLE | no message open, input stalled
//  ST_DATA | blocks pass through, lengths accumulate
//  ST_LEN  | draining the final data block (m_last=0) or presenting the length block
module ghash_block_formatter
   import ghash_block_formatter_pkg::*;
#(
   parameter bit CHECK_ORDER = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [GCM_BLOCK_W-1:0] s_data,
   input  logic [4:0]             s_bytes,
   input  logic                   s_is_aad,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [GCM_BLOCK_W-1:0] m_data,
   output logic                   m_last,
   output logic                   err,
   output logic                   busy
);

   state_e                 state_q, state_d;
   logic [GCM_LEN_W-1:0]   len_a_q, len_a_d, len_c_q, len_c_d;
   logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [GCM_BLOCK_W-1:0] m_data_q, m_data_d;
   logic                   err_q, err_d;
   logic                   seen_ct_q, seen_ct_d;
   logic                   part_aad_q, part_aad_d, part_ct_q, part_ct_d;

   logic [4:0]             bytes_cl;
   logic                   bytes_over;
   logic [GCM_BLOCK_W-1:0] keep;
   logic                   accept, pop, partial, viol;
   logic [GCM_LEN_W-1:0]   add_bits;

   gcm_byte_mask u_mask (
      .bytes_i         (s_bytes),
      .bytes_clamped_o (bytes_cl),
      .over_o          (bytes_over),
      .keep_o          (keep)
   );

   assign s_ready  = (state_q == ST_DATA) && (!m_valid_q || m_ready) && !start;
   assign accept   = s_valid && s_ready;
   assign pop      = m_valid_q && m_ready;
   assign add_bits = {{(GCM_LEN_W-8){1'b0}}, bytes_cl, 3'b000};
   assign partial  = (bytes_cl < 5'(GCM_BLOCK_BYTES));
   assign viol     = bytes_over || (s_is_aad && seen_ct_q) ||
                     (s_is_aad ? part_aad_q : part_ct_q);

   always_comb begin
      state_d    = state_q;
      len_a_d    = len_a_q;
      len_c_d    = len_c_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      m_data_d   = m_data_q;
      err_d      = err_q;
      seen_ct_d  = seen_ct_q;
      part_aad_d = part_aad_q;
      part_ct_d  = part_ct_q;
      if (start) begin
         state_d    = ST_DATA;
         len_a_d    = '0;
         len_c_d    = '0;
         m_valid_d  = 1'b0;
         m_last_d   = 1'b0;
         m_data_d   = '0;
         err_d      = 1'b0;
         seen_ct_d  = 1'b0;
         part_aad_d = 1'b0;
         part_ct_d  = 1'b0;
      end else begin
         case (state_q)
            ST_DATA: begin
               if (pop) m_valid_d = 1'b0;
               if (accept) begin
                  if (s_is_aad) begin
                     len_a_d    = len_a_q + add_bits;
                     part_aad_d = part_aad_q | partial;
                  end else begin
                     len_c_d   = len_c_q + add_bits;
                     seen_ct_d = 1'b1;
                     part_ct_d = part_ct_q | partial;
                  end
                  if (CHECK_ORDER && viol) err_d = 1'b1;
                  if (s_bytes != 5'd0) begin
                     m_valid_d = 1'b1;
                     m_last_d  = 1'b0;
                     m_data_d  = s_data & keep;
                     if (s_last) state_d = ST_LEN;
                  end else if (s_last) begin
                     // empty finish adds nothing, so current lengths are final
                     m_valid_d = 1'b1;
                     m_last_d  = 1'b1;
                     m_data_d  = {len_a_q, len_c_q};
                     state_d   = ST_LEN;
                  end
               end
            end
            ST_LEN: begin
               if (pop) begin
                  if (m_last_q) begin
                     m_valid_d = 1'b0;
                     m_last_d  = 1'b0;
                     m_data_d  = '0;
                     state_d   = ST_IDLE;
                  end else begin
                     m_valid_d = 1'b1;
                     m_last_d  = 1'b1;
                     m_data_d  = {len_a_q, len_c_q};
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_a_q    <= '0;
         len_c_q    <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         err_q      <= 1'b0;
         seen_ct_q  <= 1'b0;
         part_aad_q <= 1'b0;
         part_ct_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_a_q    <= len_a_d;
         len_c_q    <= len_c_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_data_q   <= m_data_d;
         err_q      <= err_d;
         seen_ct_q  <= seen_ct_d;
         part_aad_q <= part_aad_d;
         part_ct_q  <= part_ct_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;
   assign err     = err_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
